// File: rtl/fwb_scoreboard.sv
// FP writeback arbiter with a one-entry skid buffer and a long-latency pending-register scoreboard.
// Optional FWB_SAMECYCLE_CLEAR_EN: a register being written this cycle stops stalling issue immediately.
module fwb_scoreboard #(
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IssueValid,
  input  logic            IssueLong,
  input  logic            IssueWrites,
  input  logic [4:0]      IssueRd,
  input  logic [4:0]      IssueRs1,
  input  logic [4:0]      IssueRs2,
  input  logic [4:0]      IssueRs3,
  input  logic [2:0]      IssueUsesRs,
  output logic            HazardStall,
  input  logic            PipeWe,
  input  logic [4:0]      PipeRd,
  input  logic [FLEN-1:0] PipeWd,
  input  logic            LongValid,
  input  logic [4:0]      LongRd,
  input  logic [FLEN-1:0] LongWd,
  output logic            LongReady,
  output logic            FRegWe,
  output logic [4:0]      FRegWAdr,
  output logic [FLEN-1:0] FRegWd
);

  logic [31:0]     busy_q;
  logic            buf_valid_q;
  logic [4:0]      buf_rd_q;
  logic [FLEN-1:0] buf_wd_q;

  logic            long_accept;
  logic            long_clear;
  logic [4:0]      clear_rd;
  logic [31:0]     clear_vec;
  logic [31:0]     set_vec;
  logic [31:0]     busy_view;
  logic            src_hit;

  // Valid/ready: a long result transfers in any cycle where LongValid & LongReady are both high;
  // the producer must hold LongValid/LongRd/LongWd stable until that cycle.
  assign LongReady   = ~buf_valid_q & ~reset;
  assign long_accept = LongValid & LongReady;

  // Write port priority: pipeline, then buffered long result, then direct long result.
  always_comb begin
    FRegWe     = 1'b0;
    FRegWAdr   = '0;
    FRegWd     = '0;
    long_clear = 1'b0;
    clear_rd   = '0;
    if (!reset) begin
      if (PipeWe) begin
        FRegWe   = 1'b1;
        FRegWAdr = PipeRd;
        FRegWd   = PipeWd;
      end else if (buf_valid_q) begin
        FRegWe     = 1'b1;
        FRegWAdr   = buf_rd_q;
        FRegWd     = buf_wd_q;
        long_clear = 1'b1;
        clear_rd   = buf_rd_q;
      end else if (long_accept) begin
        FRegWe     = 1'b1;
        FRegWAdr   = LongRd;
        FRegWd     = LongWd;
        long_clear = 1'b1;
        clear_rd   = LongRd;
      end
    end
  end

  assign clear_vec = long_clear ? (32'd1 << clear_rd) : 32'd0;

`ifdef FWB_SAMECYCLE_CLEAR_EN
  assign busy_view = busy_q & ~clear_vec;
`else
  assign busy_view = busy_q;
`endif

  assign src_hit = (IssueUsesRs[0] & busy_view[IssueRs1]) |
                   (IssueUsesRs[1] & busy_view[IssueRs2]) |
                   (IssueUsesRs[2] & busy_view[IssueRs3]);

  assign HazardStall = ~reset & IssueValid & (src_hit | (IssueWrites & busy_view[IssueRd]));

  assign set_vec = (IssueValid & ~HazardStall & IssueLong & IssueWrites) ?
                   (32'd1 << IssueRd) : 32'd0;

  // Set is OR'd after the clear so a same-cycle set on the same register wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_wd_q    <= '0;
    end else begin
      busy_q <= (busy_q & ~clear_vec) | set_vec;
      if (PipeWe && long_accept) begin
        buf_valid_q <= 1'b1;
        buf_rd_q    <= LongRd;
        buf_wd_q    <= LongWd;
      end else if (!PipeWe && buf_valid_q) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

endmodule
